// File: rtl/tmds_decoder.sv
// tmds_decoder: per-channel TMDS receive decoder.
// Classifies each 10-bit symbol as a control token or video, recovers the
// video byte / control bits with a 2-clock latency, and runs a control-period
// lock state machine. Define TMDS_DISP_CHECK_EN to add running-disparity
// tracking, disparity error reporting and error-driven loss of lock.
module tmds_decoder #(
    parameter int CTRL_RUN  = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [9:0]  tmds_in,
    input  logic        valid_in,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        ve_out,
    output logic        valid_out,
    output logic        locked_out,
    output logic        disp_err_out,
    output logic [15:0] err_count_out
);

    localparam int RUN_W = (CTRL_RUN > 2) ? $clog2(CTRL_RUN) : 1;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Reject parameter values the lock logic cannot honour.
    if (CTRL_RUN < 2 || ERR_LIMIT < 1) begin : g_param_check
        $error("tmds_decoder: CTRL_RUN must be >= 2 and ERR_LIMIT >= 1");
    end

    // ---------------- input classification ----------------
    logic       w_is_ctrl;
    logic [1:0] w_ctrl_bits;

    // Match the four control tokens; anything else is video.
    always_comb begin
        w_is_ctrl   = 1'b1;
        w_ctrl_bits = 2'b00;
        case (tmds_in)
            10'b1101010100: w_ctrl_bits = 2'b00;
            10'b0010101011: w_ctrl_bits = 2'b01;
            10'b0101010100: w_ctrl_bits = 2'b10;
            10'b1010101011: w_ctrl_bits = 2'b11;
            default:        w_is_ctrl   = 1'b0;
        endcase
    end

    // ---------------- stage 1 ----------------
    logic [9:0] r_sym;
    logic       r_s1_ctrl;
    logic [1:0] r_s1_cbits;
    logic       r_s1_valid;
    logic       r_s1_err;

    // Capture the symbol and its classification; hold them through invalid cycles.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sym      <= '0;
            r_s1_ctrl  <= 1'b0;
            r_s1_cbits <= 2'b00;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_sym      <= tmds_in;
                r_s1_ctrl  <= w_is_ctrl;
                r_s1_cbits <= w_ctrl_bits;
            end
        end
    end

`ifdef TMDS_DISP_CHECK_EN
    // Disparity arithmetic is done modulo 32 on a 5-bit two's-complement count,
    // exactly as the transmitter's counter wraps.
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_next;
    logic [7:0] w_in_d;
    logic [3:0] w_n1;
    logic [4:0] w_diff;     // n1 - n0
    logic [4:0] w_q8x2;     // 2 * q_m[8]
    logic [4:0] w_nq8x2;    // 2 * ~q_m[8]
    logic       w_bal;
    logic       w_exp9;
    logic       w_mismatch;

    // Rebuild q_m from the received symbol and predict the encoder's bit 9.
    always_comb begin
        w_in_d     = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        w_n1       = 4'($countones(w_in_d));
        w_diff     = {w_n1, 1'b0} - 5'd8;
        w_q8x2     = {3'b000, tmds_in[8], 1'b0};
        w_nq8x2    = {3'b000, ~tmds_in[8], 1'b0};
        w_bal      = (r_cnt == 5'd0) || (w_n1 == 4'd4);
        w_exp9     = 1'b0;
        w_cnt_next = r_cnt;
        if (w_bal) begin
            w_exp9     = ~tmds_in[8];
            w_cnt_next = tmds_in[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else begin
            w_exp9 = (!r_cnt[4] && (w_n1 > 4'd4)) || (r_cnt[4] && (w_n1 < 4'd4));
            if (tmds_in[9]) begin
                w_cnt_next = r_cnt + w_q8x2 - w_diff;
            end else begin
                w_cnt_next = r_cnt - w_nq8x2 + w_diff;
            end
        end
        w_mismatch = valid_in && !w_is_ctrl && (w_exp9 != tmds_in[9]);
    end

    // Track the running disparity, resynchronising on the received bit 9.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt    <= '0;
            r_s1_err <= 1'b0;
        end else begin
            r_s1_err <= w_mismatch;
            if (valid_in) begin
                r_cnt <= w_is_ctrl ? 5'd0 : w_cnt_next;
            end
        end
    end
`else
    assign r_s1_err = 1'b0;
`endif

    // ---------------- stage 2 ----------------
    logic [7:0] w_s2_d;
    logic [7:0] w_dec;

    // Undo the optional inversion and the XOR/XNOR chaining of the encoder.
    always_comb begin
        w_s2_d   = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_dec    = '0;
        w_dec[0] = w_s2_d[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_sym[8] ? (w_s2_d[i] ^ w_s2_d[i-1]) : ~(w_s2_d[i] ^ w_s2_d[i-1]);
        end
    end

    // Output registers: video updates data, control updates control bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out    <= '0;
            control_out <= 2'b00;
            ve_out      <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_ctrl) begin
                    ve_out      <= 1'b0;
                    control_out <= r_s1_cbits;
                end else begin
                    ve_out   <= 1'b1;
                    data_out <= w_dec;
                end
            end
        end
    end

`ifdef TMDS_DISP_CHECK_EN
    // Error pulse aligned with valid_out and a saturating error tally.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            disp_err_out  <= 1'b0;
            err_count_out <= '0;
        end else begin
            disp_err_out <= r_s1_err;
            if (r_s1_err && (err_count_out != 16'hFFFF)) begin
                err_count_out <= err_count_out + 16'd1;
            end
        end
    end
`else
    assign disp_err_out  = 1'b0;
    assign err_count_out = 16'd0;
`endif

    // ---------------- lock FSM ----------------
    lock_state_e r_state, w_state_next;
    logic [RUN_W-1:0] r_run, w_run_next;
`ifdef TMDS_DISP_CHECK_EN
    localparam int ACC_W = $clog2(ERR_LIMIT + 1);
    logic [ACC_W-1:0] r_acc, w_acc_next;
`endif

    // State register for lock state, control-run counter and error accumulator.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_SEARCH;
            r_run   <= '0;
`ifdef TMDS_DISP_CHECK_EN
            r_acc   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_run   <= w_run_next;
`ifdef TMDS_DISP_CHECK_EN
            r_acc   <= w_acc_next;
`endif
        end
    end

    // Next-state logic driven by the symbol currently held in stage 1.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
`ifdef TMDS_DISP_CHECK_EN
        w_acc_next   = r_acc;
`endif
        if (r_s1_valid) begin
            if (r_s1_ctrl) begin
                if (r_run == RUN_W'(CTRL_RUN - 1)) begin
                    // A full control run locks and forgives past errors.
                    w_run_next   = '0;
                    w_state_next = ST_LOCKED;
`ifdef TMDS_DISP_CHECK_EN
                    w_acc_next   = '0;
`endif
                end else begin
                    w_run_next = r_run + 1'b1;
                end
            end else begin
                w_run_next = '0;
`ifdef TMDS_DISP_CHECK_EN
                if (r_s1_err && (r_state == ST_LOCKED)) begin
                    if (int'(r_acc) + 1 >= ERR_LIMIT) begin
                        w_state_next = ST_SEARCH;
                        w_acc_next   = '0;
                    end else begin
                        w_acc_next = r_acc + 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign locked_out = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// Testbench for tmds_decoder: directed steps followed by random symbol
// streams, checked against a symbol-level reference model.
module tb_tmds_decoder;

    localparam int CTRL_RUN  = 8;
    localparam int ERR_LIMIT = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [9:0]  tmds_in;
    logic        valid_in;
    logic [7:0]  data_out;
    logic [1:0]  control_out;
    logic        ve_out;
    logic        valid_out;
    logic        locked_out;
    logic        disp_err_out;
    logic [15:0] err_count_out;

    tmds_decoder #(.CTRL_RUN(CTRL_RUN), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .tmds_in       (tmds_in),
        .valid_in      (valid_in),
        .data_out      (data_out),
        .control_out   (control_out),
        .ve_out        (ve_out),
        .valid_out     (valid_out),
        .locked_out    (locked_out),
        .disp_err_out  (disp_err_out),
        .err_count_out (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (values the DUT should present for the last symbol).
    logic [7:0]  m_data;
    logic [1:0]  m_ctrl;
    logic        m_ve, m_valid, m_derr, m_locked;
    logic [15:0] m_ecnt;
    int          m_run, m_acc, m_cnt;

    // Snapshot compared after the next clock edge.
    logic [7:0]  p_data;
    logic [1:0]  p_ctrl;
    logic        p_ve, p_valid, p_derr, p_locked;
    logic [15:0] p_ecnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".data"},    16'(data_out),     16'(p_data));
        chk({tag, ".ctrl"},    16'(control_out),  16'(p_ctrl));
        chk({tag, ".ve"},      16'(ve_out),       16'(p_ve));
        chk({tag, ".valid"},   16'(valid_out),    16'(p_valid));
        chk({tag, ".locked"},  16'(locked_out),   16'(p_locked));
        chk({tag, ".derr"},    16'(disp_err_out), 16'(p_derr));
        chk({tag, ".errcnt"},  err_count_out,     p_ecnt);
    endtask

    task automatic model_reset();
        m_data = '0; m_ctrl = '0; m_ve = 0; m_valid = 0; m_derr = 0;
        m_locked = 0; m_ecnt = '0; m_run = 0; m_acc = 0; m_cnt = 0;
    endtask

    function automatic int wrap5(input int v);
        int r;
        r = ((v % 32) + 32) % 32;
        return (r >= 16) ? r - 32 : r;
    endfunction

    // Apply one symbol to the reference model.
    task automatic model_apply(input logic [9:0] s, input logic v);
        logic [7:0] d;
        bit         is_ctrl;
        logic [1:0] cb;
        int         n1, n0, q8;
        bit         exp9, err;
        m_valid = v;
        m_derr  = 0;
        if (!v) return;
        is_ctrl = 1;
        cb = 2'b00;
        if      (s == 10'b1101010100) cb = 2'b00;
        else if (s == 10'b0010101011) cb = 2'b01;
        else if (s == 10'b0101010100) cb = 2'b10;
        else if (s == 10'b1010101011) cb = 2'b11;
        else is_ctrl = 0;
        if (is_ctrl) begin
            m_ve   = 0;
            m_ctrl = cb;
            m_cnt  = 0;
            m_run++;
            if (m_run == CTRL_RUN) begin
                m_run = 0; m_acc = 0; m_locked = 1;
            end
        end else begin
            m_ve  = 1;
            m_run = 0;
            d = s[9] ? ~s[7:0] : s[7:0];
            m_data[0] = d[0];
            for (int i = 1; i < 8; i++)
                m_data[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
            n1 = $countones(d);
            n0 = 8 - n1;
            q8 = int'(s[8]);
            if (m_cnt == 0 || n1 == n0) exp9 = (q8 == 0);
            else exp9 = (m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1);
            err = (exp9 != s[9]);
            if (m_cnt == 0 || n1 == n0) m_cnt = wrap5(m_cnt + (q8 != 0 ? n1 - n0 : n0 - n1));
            else if (s[9])              m_cnt = wrap5(m_cnt + 2 * q8 + n0 - n1);
            else                        m_cnt = wrap5(m_cnt - 2 * (1 - q8) + n1 - n0);
`ifdef TMDS_DISP_CHECK_EN
            if (err) begin
                m_derr = 1;
                if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
                if (m_locked) begin
                    m_acc++;
                    if (m_acc >= ERR_LIMIT) begin
                        m_locked = 0; m_acc = 0;
                    end
                end
            end
`else
            if (err) m_acc = 0;
`endif
        end
    endtask

    // One clock: drive a symbol, then check what the previous symbol produced.
    task automatic step(input logic [9:0] s, input logic v, input string tag);
        p_data = m_data; p_ctrl = m_ctrl; p_ve = m_ve; p_valid = m_valid;
        p_derr = m_derr; p_locked = m_locked; p_ecnt = m_ecnt;
        model_apply(s, v);
        tmds_in  = s;
        valid_in = v;
        @(posedge clk_in);
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between edges, verify immediate clearing, release later.
    task automatic apply_reset(input string tag);
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        #1;
        model_reset();
        p_data = '0; p_ctrl = '0; p_ve = 0; p_valid = 0;
        p_derr = 0; p_locked = 0; p_ecnt = '0;
        check_outputs(tag);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        $display("reset %s released at %0t", tag, $time);
    endtask

    initial begin
        logic [9:0] sym;
        int         kind;
        logic [9:0] tok [4];
        tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
        rst_n_in = 1'b0;
        tmds_in  = '0;
        valid_in = 1'b0;
        model_reset();
        #3;
        apply_reset("por");

        // Lock acquisition on eight 00 tokens.
        for (int i = 0; i < CTRL_RUN; i++) step(10'h354, 1'b1, "lock_run");
        step(10'h354, 1'b0, "lock_seen");
        step(10'h354, 1'b0, "lock_hold");
        $display("lock: locked_out=%0d expected 1", locked_out);

        // Each control value.
        step(10'h0AB, 1'b1, "ctrl01");
        step(10'h154, 1'b1, "ctrl10");
        step(10'h2AB, 1'b1, "ctrl11");
        step(10'h354, 1'b1, "ctrl00");

        // Simple video decode.
        step(10'h100, 1'b1, "vid100");
        step(10'h200, 1'b1, "vid200");

        // Disparity violations while locked.
        step(10'h354, 1'b1, "dsp_ctrl");
        step(10'h100, 1'b1, "dsp_a");
        step(10'h100, 1'b1, "dsp_b");
        step(10'h200, 1'b1, "dsp_c");
        step(10'h100, 1'b1, "dsp_d");
        step(10'h200, 1'b1, "dsp_e");
        step(10'h100, 1'b1, "dsp_f");
        step(10'h100, 1'b0, "dsp_drain1");
        step(10'h100, 1'b0, "dsp_drain2");
        $display("errors: locked_out=%0d err_count_out=%0d", locked_out, err_count_out);

        // valid_in gap mid-video.
        step(10'h1F0, 1'b1, "gap_v0");
        step(10'h3C7, 1'b0, "gap_i0");
        step(10'h0AB, 1'b0, "gap_i1");
        step(10'h25A, 1'b1, "gap_v1");
        step(10'h25A, 1'b0, "gap_i2");

        // Reset mid-stream with symbols in flight.
        step(10'h0AB, 1'b1, "pre_rst");
        apply_reset("mid");
        step(10'h16D, 1'b1, "post_rst0");
        step(10'h16D, 1'b0, "post_rst1");
        step(10'h16D, 1'b0, "post_rst2");

        // Random stream with occasional control bursts and invalid cycles.
        for (int n = 0; n < 800; n++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 5) begin
                for (int k = 0; k < CTRL_RUN + 2; k++)
                    step(tok[$urandom_range(0, 3)], 1'b1, "rnd_burst");
            end else if (kind < 20) begin
                step(tok[$urandom_range(0, 3)], 1'b1, "rnd_ctrl");
            end else if (kind < 32) begin
                sym = 10'($urandom);
                step(sym, 1'b0, "rnd_idle");
            end else begin
                sym = 10'($urandom);
                step(sym, 1'b1, "rnd_video");
            end
        end
        step(10'h000, 1'b0, "final0");
        step(10'h000, 1'b0, "final1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
